edusoc_lsu: RTL and testbench

Core-side load/store unit; the initiator end of the SoC data memory bus (req/valid/we/be/addr/wdata/rdata) that the SoC serves as responder. Accepts one load or store command from the core pipeline and generates byte enables and lane-replicated write data. Drives a single bus transaction and returns aligned, sign- or zero-extended load data with a done/error pulse. Sits between the core execute stage and the data bus ports.

---
 rtl/edusoc_lsu_pkg.sv | 33 +++
 rtl/edusoc_lsu_if.sv | 20 ++
 rtl/edusoc_lsu_align.sv | 44 ++++
 rtl/edusoc_lsu.sv | 156 +++++++++++++++
 tb/tb_edusoc_lsu.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/edusoc_lsu_pkg.sv
// Shared types and byte-enable helpers for the edusoc load/store unit.
package edusoc_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } lsu_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_t;

    function automatic logic [3:0] lsu_be(input lsu_size_t size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: lsu_be = 4'b0001 << addr_lo;
            SZ_HALF: lsu_be = 4'b0011 << addr_lo;
            default: lsu_be = 4'b1111;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input lsu_size_t size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: lsu_misaligned = 1'b0;
            SZ_HALF: lsu_misaligned = addr_lo[0];
            default: lsu_misaligned = |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/edusoc_lsu_if.sv
// Data memory bus between the LSU (master) and the SoC memory responder (slave).
interface edusoc_lsu_if;
    logic        data_req;
    logic        data_valid;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_valid, data_rdata
    );

    modport slave (
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_valid, data_rdata
    );
endinterface

// File: rtl/edusoc_lsu_align.sv
// Combinational lane handling: store-data replication and load-lane extraction
// with sign/zero extension.
module edusoc_lsu_align
    import edusoc_lsu_pkg::*;
(
    input  lsu_size_t   i_wr_size,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_wr_lanes,
    input  lsu_size_t   i_rd_size,
    input  logic        i_rd_unsigned,
    input  logic [1:0]  i_rd_lane,
    input  logic [31:0] i_rd_word,
    output logic [31:0] o_rd_data
);

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic zext);
        return zext ? {24'h0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic zext);
        return zext ? {16'h0, h} : {{16{h[15]}}, h};
    endfunction

    logic [31:0] w_shifted;

    assign w_shifted = i_rd_word >> {i_rd_lane, 3'b000};

    always_comb begin
        o_wr_lanes = i_wr_data;
        case (i_wr_size)
            SZ_BYTE: o_wr_lanes = {4{i_wr_data[7:0]}};
            SZ_HALF: o_wr_lanes = {2{i_wr_data[15:0]}};
            default: o_wr_lanes = i_wr_data;
        endcase

        o_rd_data = w_shifted;
        case (i_rd_size)
            SZ_BYTE: o_rd_data = ext8(w_shifted[7:0], i_rd_unsigned);
            SZ_HALF: o_rd_data = ext16(w_shifted[15:0], i_rd_unsigned);
            default: o_rd_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/edusoc_lsu.sv
// Load/store unit: one core command -> one data-bus transaction -> done/err pulse.
// Optional bus timeout is enabled with `define EDUSOC_LSU_TIMEOUT_EN.
module edusoc_lsu
    import edusoc_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           core_clk,
    input  logic           core_res,
    input  logic           lsu_start,
    input  logic           lsu_we,
    input  logic [1:0]     lsu_size,
    input  logic           lsu_unsigned,
    input  logic [31:0]    lsu_addr,
    input  logic [31:0]    lsu_wdata,
    output logic           lsu_busy,
    output logic           lsu_done,
    output logic           lsu_err,
    output logic [31:0]    lsu_rdata,
    edusoc_lsu_if.master   bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    lsu_state_t  r_state, w_next_state;
    logic        r_req, r_we, r_unsigned, r_err;
    lsu_size_t   r_size;
    logic [1:0]  r_lane;
    logic [3:0]  r_be;
    logic [29:0] r_addr_hi;
    logic [31:0] r_wdata, r_rdata;

    lsu_size_t   w_size;
    logic        w_misaligned, w_accept, w_complete, w_abort, w_expired;
    logic [31:0] w_wr_lanes, w_rd_data;

    assign w_size       = lsu_size_t'(lsu_size);
    assign w_misaligned = lsu_misaligned(w_size, lsu_addr[1:0]);

    edusoc_lsu_align u_align (
        .i_wr_size     (w_size),
        .i_wr_data     (lsu_wdata),
        .o_wr_lanes    (w_wr_lanes),
        .i_rd_size     (r_size),
        .i_rd_unsigned (r_unsigned),
        .i_rd_lane     (r_lane),
        .i_rd_word     (bus.data_rdata),
        .o_rd_data     (w_rd_data)
    );

`ifdef EDUSOC_LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // Counter is held at zero outside BUSY, so it starts fresh on every entry.
    always_ff @(posedge core_clk) begin
        if (core_res || r_state != ST_BUSY) begin
            r_cnt <= '0;
        end else if (!bus.data_valid) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge core_clk) begin
        if (core_res) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (lsu_start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_misaligned ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A response in the limit cycle still completes normally.
                if (bus.data_valid) begin
                    w_complete   = 1'b1;
                    w_next_state = ST_DONE;
                end else if (w_expired) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_res) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_lane     <= 2'b00;
            r_be       <= 4'h0;
            r_addr_hi  <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_accept && !w_misaligned) begin
                r_req      <= 1'b1;
                r_we       <= lsu_we;
                r_size     <= w_size;
                r_unsigned <= lsu_unsigned;
                r_lane     <= lsu_addr[1:0];
                r_be       <= lsu_be(w_size, lsu_addr[1:0]);
                r_addr_hi  <= lsu_addr[31:2];
                r_wdata    <= w_wr_lanes;
            end
            if (w_accept && w_misaligned) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end
            if (w_complete) begin
                r_req   <= 1'b0;
                r_err   <= 1'b0;
                r_rdata <= r_we ? 32'h0 : w_rd_data;
            end
            if (w_abort) begin
                r_req   <= 1'b0;
                r_err   <= 1'b1;
                r_rdata <= '0;
            end
        end
    end

    assign lsu_busy       = (r_state != ST_IDLE);
    assign lsu_done       = (r_state == ST_DONE);
    assign lsu_err        = r_err;
    assign lsu_rdata      = r_rdata;
    assign bus.data_req   = r_req;
    assign bus.data_we    = r_we;
    assign bus.data_be    = r_be;
    assign bus.data_addr  = {r_addr_hi, 2'b00};
    assign bus.data_wdata = r_wdata;

endmodule

// File: tb/tb_edusoc_lsu.sv
// Randomized scoreboard bench for edusoc_lsu with a behavioural bus/response model.
module tb_edusoc_lsu;

`ifdef EDUSOC_LSU_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 4;
`else
    localparam int TIMEOUT_CYCLES = 255;
`endif

    logic        core_clk = 1'b0;
    logic        core_res = 1'b1;
    logic        lsu_start = 1'b0, lsu_we = 1'b0, lsu_unsigned = 1'b0;
    logic [1:0]  lsu_size = 2'b00;
    logic [31:0] lsu_addr = 32'h0, lsu_wdata = 32'h0;
    logic        lsu_busy, lsu_done, lsu_err;
    logic [31:0] lsu_rdata;

    edusoc_lsu_if bus();

    edusoc_lsu #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .core_clk     (core_clk),
        .core_res     (core_res),
        .lsu_start    (lsu_start),
        .lsu_we       (lsu_we),
        .lsu_size     (lsu_size),
        .lsu_unsigned (lsu_unsigned),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_busy     (lsu_busy),
        .lsu_done     (lsu_done),
        .lsu_err      (lsu_err),
        .lsu_rdata    (lsu_rdata),
        .bus          (bus)
    );

    always #5 core_clk = ~core_clk;

    int cyc = 0;
    always @(posedge core_clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus responder: answers after s_delay request cycles, random noise on valid while idle.
    int          s_delay = 0;
    int          s_cnt = 0;
    logic [31:0] s_rdata = 32'h0;
    logic        s_noise = 1'b0;

    always @(posedge core_clk) begin
        if (!bus.data_req || bus.data_valid) s_cnt <= 0;
        else                                 s_cnt <= s_cnt + 1;
    end
    always @(negedge core_clk) s_noise <= 1'($urandom_range(0, 1));

    assign bus.data_valid = bus.data_req ? (s_cnt == s_delay) : s_noise;
    assign bus.data_rdata = s_rdata;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } done_exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } bus_exp_t;

    done_exp_t dq[$];
    bus_exp_t  bq[$];

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // Completion monitor
    always @(negedge core_clk) begin
        done_exp_t d;
        if (lsu_done === 1'b1) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                d = dq.pop_front();
                chk("done_cycle", cyc, d.cyc);
                chk("done_err", {31'b0, lsu_err}, {31'b0, d.err});
                chk("done_rdata", lsu_rdata, d.rdata);
            end
        end
    end

    // Bus monitor
    logic     prev_req = 1'b0;
    bus_exp_t cur;
    int       rlen = 0;

    always @(negedge core_clk) begin
        if (bus.data_req === 1'b1) begin
            if (prev_req !== 1'b1) begin
                rlen = 1;
                if (bq.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    cur = bq.pop_front();
                    chk("bus_addr", bus.data_addr, cur.addr);
                    chk("bus_we", {31'b0, bus.data_we}, {31'b0, cur.we});
                    chk("bus_be", {28'b0, bus.data_be}, {28'b0, cur.be});
                    if (cur.we) chk("bus_wdata", bus.data_wdata, cur.wdata);
                end
            end else begin
                rlen++;
                chk("bus_hold_addr", bus.data_addr, cur.addr);
                chk("bus_hold_be", {28'b0, bus.data_be}, {28'b0, cur.be});
            end
        end else if (prev_req === 1'b1) begin
            chk("req_len", rlen, cur.len);
        end
        prev_req = bus.data_req;
    end

    task automatic randomize_cmd_inputs();
        lsu_we       = 1'($urandom_range(0, 1));
        lsu_size     = 2'($urandom_range(0, 3));
        lsu_unsigned = 1'($urandom_range(0, 1));
        lsu_addr     = $urandom;
        lsu_wdata    = $urandom;
    endtask

    // Issue one command at the current negedge, push expectations, then
    // keep driving (possibly asserted) start until the unit is idle again.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int delay, input logic [31:0] rd,
                         input int gap, input bit hammer);
        int        n, lo, len;
        logic      mis;
        bus_exp_t  b;
        done_exp_t d;
        logic [31:0] v, m;
        n   = nbytes(sz);
        lo  = int'(addr[1:0]);
        mis = (lo % n) != 0;
        s_delay = delay;
        s_rdata = rd;
        lsu_start = 1'b1; lsu_we = we; lsu_size = sz; lsu_unsigned = uns;
        lsu_addr = addr;  lsu_wdata = wdata;
        if (mis) begin
            d.cyc = cyc + 1; d.err = 1'b1; d.rdata = 32'h0;
        end else begin
            len   = delay + 1;
            d.err = 1'b0;
`ifdef EDUSOC_LSU_TIMEOUT_EN
            if (delay >= TIMEOUT_CYCLES) begin
                len   = TIMEOUT_CYCLES;
                d.err = 1'b1;
            end
`endif
            d.cyc  = cyc + 1 + len;
            b.we   = we;
            b.addr = addr & ~32'd3;
            b.be   = 4'(((1 << n) - 1) << lo);
            for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wdata[8*(i % n) +: 8];
            b.len  = len;
            bq.push_back(b);
            if (we || d.err) begin
                d.rdata = 32'h0;
            end else begin
                v = rd >> (8 * lo);
                m = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
                v = v & m;
                if (!uns && v[8*n-1]) v = v | ~m;
                d.rdata = v;
            end
        end
        dq.push_back(d);
        @(negedge core_clk);
        while (cyc < d.cyc + 1) begin
            lsu_start = hammer ? 1'b1 : 1'($urandom_range(0, 1));
            randomize_cmd_inputs();
            @(negedge core_clk);
        end
        lsu_start = 1'b0;
        repeat (gap) @(negedge core_clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"},   {31'b0, bus.data_req}, 32'd0);
        chk({tag, "_we"},    {31'b0, bus.data_we}, 32'd0);
        chk({tag, "_be"},    {28'b0, bus.data_be}, 32'd0);
        chk({tag, "_addr"},  bus.data_addr, 32'd0);
        chk({tag, "_wdata"}, bus.data_wdata, 32'd0);
        chk({tag, "_busy"},  {31'b0, lsu_busy}, 32'd0);
        chk({tag, "_done"},  {31'b0, lsu_done}, 32'd0);
        chk({tag, "_err"},   {31'b0, lsu_err}, 32'd0);
        chk({tag, "_rdata"}, lsu_rdata, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_exp_t rb;
        repeat (3) @(negedge core_clk);
        check_all_zero("reset");
        core_res = 1'b0;
        @(negedge core_clk);

        // Directed cases
        issue(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 2, 32'h0, 1, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 1, 32'h8001_1234, 0, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 0, 32'h8001_1234, 1, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 0, 32'h0, 0, 1'b0);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_3002, 32'h0, 0, 32'h0, 0, 1'b0);

        // Back-to-back loads against a zero-wait responder, start held high
        for (int i = 0; i < 6; i++)
            issue(1'b0, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  {$urandom_range(0, 32'hFFFF), 2'b00}, $urandom, 0, $urandom, 0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 60; i++)
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, $urandom_range(0, 6), $urandom,
                  $urandom_range(0, 2), 1'($urandom_range(0, 1)));

        // Slow responder: beyond any timeout limit when enabled
        issue(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 40, 32'h1357_9BDF, 0, 1'b0);

        // Leave err=1 latched, then reset while BUSY with valid in the reset cycle
        issue(1'b0, 2'b10, 1'b0, 32'h0000_6002, 32'h0, 0, 32'h0, 0, 1'b0);
        s_delay = 2;
        s_rdata = 32'hDEAD_BEEF;
        lsu_start = 1'b1; lsu_we = 1'b0; lsu_size = 2'b10; lsu_unsigned = 1'b0;
        lsu_addr = 32'h0000_4000; lsu_wdata = 32'h0;
        rb.we = 1'b0; rb.be = 4'hF; rb.addr = 32'h0000_4000; rb.wdata = 32'h0;
        rb.len = (TIMEOUT_CYCLES < 3) ? TIMEOUT_CYCLES : 3;
        bq.push_back(rb);
        @(negedge core_clk);
        lsu_start = 1'b0;
        repeat (2) @(negedge core_clk);
        core_res = 1'b1;
        @(negedge core_clk);
        core_res = 1'b0;
        check_all_zero("midrst");
        repeat (4) @(negedge core_clk);

        chk("pending_done", dq.size(), 32'd0);
        chk("pending_req", bq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
